// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one CHUNK_W-bit carry-lookahead chunk adder applied
// over NUM_CHUNKS cycles, LSB first. Optional macro WIDE_ADD_SUB_EN adds port sub (a-b).
module wide_add_sequencer #(
    parameter int CHUNK_W    = 16,
    parameter int NUM_CHUNKS = 4,
    localparam int WIDTH     = CHUNK_W * NUM_CHUNKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int IDX_W = $clog2(NUM_CHUNKS);
    localparam int NGRP  = CHUNK_W / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic               last_chunk;

    logic [CHUNK_W-1:0] op_a, op_b, g, p, chunk_sum;
    logic [CHUNK_W:0]   c;
    logic [NGRP-1:0]    grp_g, grp_p;
    logic [WIDTH-1:0]   sum_next;
    logic               accept;

    assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));
    assign accept     = (state == IDLE) && in_valid;

    // Chunk adder: 4-bit generate/propagate groups; group carries are looked
    // ahead, bit carries inside each group are formed from the group carry-in.
    always_comb begin
        logic gc;
        logic bc;
        op_a = a_reg[idx*CHUNK_W +: CHUNK_W];
        op_b = b_reg[idx*CHUNK_W +: CHUNK_W];
        g    = op_a & op_b;
        p    = op_a ^ op_b;
        c    = '0;
        gc   = carry_reg;
        for (int k = 0; k < NGRP; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
            bc = gc;
            for (int j = 0; j < 4; j++) begin
                c[4*k+j] = bc;
                bc = g[4*k+j] | (p[4*k+j] & bc);
            end
            gc = grp_g[k] | (grp_p[k] & gc);
        end
        c[CHUNK_W] = gc;
        chunk_sum  = p ^ c[CHUNK_W-1:0];
    end

    always_comb begin
        sum_next = sum;
        sum_next[idx*CHUNK_W +: CHUNK_W] = chunk_sum;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN:  if (last_chunk) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: operand registers carry no reset; they are always loaded on
    // acceptance before being read, so a reset term would only cost logic.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
`ifdef WIDE_ADD_SUB_EN
            b_reg <= sub ? ~b : b;
`else
            b_reg <= b;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
`ifdef WIDE_ADD_SUB_EN
                    carry_reg <= sub ? 1'b1 : cin;
`else
                    carry_reg <= cin;
`endif
                    idx <= '0;
                end
                RUN: begin
                    sum       <= sum_next;
                    carry_reg <= c[CHUNK_W];
                    if (last_chunk) begin
                        cout <= c[CHUNK_W];
                        ovf  <= c[CHUNK_W-1] ^ c[CHUNK_W];
                        zero <= (sum_next == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (CHUNK_W=16, NUM_CHUNKS=4): directed
// cases, hold/reset/back-to-back scenarios and random ops against an arithmetic model.
module tb_wide_add_sequencer;

    localparam int CHUNK_W    = 16;
    localparam int NUM_CHUNKS = 4;
    localparam int WIDTH      = CHUNK_W * NUM_CHUNKS;
`ifdef WIDE_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, zero;

    int tests = 0;
    int fails = 0;

    wide_add_sequencer #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef WIDE_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, signed overflow from operand/result signs.
    task automatic model(input logic [WIDTH-1:0] ma, mb, input logic mcin, msub,
                         output logic [WIDTH-1:0] s, output logic co, ov, z);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] bb;
        logic             c0;
        bb = msub ? ~mb : mb;
        c0 = msub ? 1'b1 : mcin;
        r  = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
        s  = r[WIDTH-1:0];
        co = r[WIDTH];
        ov = (ma[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != ma[WIDTH-1]);
        z  = (s == '0);
    endtask

    // Presents an operand pair, waits for acceptance and returns #1 after the
    // accepting edge with in_valid dropped.
    task automatic start_op(input logic [WIDTH-1:0] oa, ob, input logic ocin, osub);
        int n = 0;
        a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tests++; if (sum !== '0)         begin fails++; $display("FAIL reset_sum: got %h want 0", sum); end
        tests++; if (cout !== 1'b0)      begin fails++; $display("FAIL reset_cout: got %0b want 0", cout); end
        tests++; if (ovf !== 1'b0)       begin fails++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] ta [2];
        logic [WIDTH-1:0] tb [2];
        logic [WIDTH-1:0] es [2];
        logic [2:0]       ef [2];   // {cout, ovf, zero}
        int lat;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'h1; es[0] = 64'h0;                   ef[0] = 3'b101;
        ta[1] = 64'h7FFF_FFFF_FFFF_FFFF; tb[1] = 64'h1; es[1] = 64'h8000_0000_0000_0000; ef[1] = 3'b010;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i], 1'b0, 1'b0);
            tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL dir%0d_run_flags: in_ready=%0b out_valid=%0b want 0/0", i, in_ready, out_valid);
            end
            wait_done(lat);
            tests++; if (lat != NUM_CHUNKS) begin fails++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NUM_CHUNKS); end
            tests++; if (sum !== es[i]) begin fails++; $display("FAIL dir%0d_sum: got %h want %h", i, sum, es[i]); end
            tests++; if ({cout, ovf, zero} !== ef[i]) begin
                fails++; $display("FAIL dir%0d_flags: got cout/ovf/zero=%b want %b", i, {cout, ovf, zero}, ef[i]);
            end
            consume;
        end
    endtask

    task automatic test_hold;
        int  lat;
        bit  seen_valid = 1'b0;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL hold%0d_handshake: out_valid=%0b in_ready=%0b want 1/0", i, out_valid, in_ready);
            end
            tests++; if (sum !== 64'h0 || cout !== 1'b1) begin
                fails++; $display("FAIL hold%0d_result: sum=%h cout=%0b want 0/1", i, sum, cout);
            end
        end
        in_valid = 1'b0;
        consume;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hold_release_in_ready: got %0b want 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        tests++; if (seen_valid) begin fails++; $display("FAIL hold_no_accept: out_valid seen=1 want 0"); end
    endtask

    task automatic test_reset_mid;
        int lat;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_handshake: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
        tests++; if (sum !== '0 || cout !== 1'b0) begin
            fails++; $display("FAIL rstmid_result: sum=%h cout=%0b want 0/0", sum, cout);
        end
        start_op(64'h0, 64'h0, 1'b1, 1'b0);
        wait_done(lat);
        tests++; if (sum !== 64'h1 || lat != NUM_CHUNKS) begin
            fails++; $display("FAIL rstmid_next_op: sum=%h lat=%0d want 1/%0d", sum, lat, NUM_CHUNKS);
        end
        consume;
    endtask

    task automatic test_back_to_back;
        int lat;
        int n = 0;
        out_ready = 1'b1;
        a = 64'h0000_FFFF_0000_FFFF; b = 64'h0000_0001_0000_0001; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        a = 64'd3; b = 64'd4;
        wait_done(lat);
        tests++; if (sum !== 64'h0001_0000_0001_0000 || lat != NUM_CHUNKS) begin
            fails++; $display("FAIL b2b_first: sum=%h lat=%0d want 0001000000010000/%0d", sum, lat, NUM_CHUNKS);
        end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_no_bypass: in_ready=%0b want 0", in_ready); end
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_idle_gap: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_second_accept: in_ready=%0b want 0", in_ready); end
        wait_done(lat);
        tests++; if (sum !== 64'd7 || lat != NUM_CHUNKS) begin
            fails++; $display("FAIL b2b_second: sum=%h lat=%0d want 7/%0d", sum, lat, NUM_CHUNKS);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] ra, rb, es;
        logic rc, rs, eco, eov, ez;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ;
                1: rb = ~ra;
                2: rb = -ra;
                default: begin ra = {1'b0, {(WIDTH-1){1'b1}}}; rb = 64'($urandom_range(0, 2)); end
            endcase
            rc = 1'($urandom_range(0, 1));
            rs = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            model(ra, rb, rc, rs, es, eco, eov, ez);
            start_op(ra, rb, rc, rs);
            wait_done(lat);
            tests++; if ({sum, cout, ovf, zero} !== {es, eco, eov, ez} || lat != NUM_CHUNKS) begin
                fails++;
                $display("FAIL rand%0d: a=%h b=%h cin=%0b sub=%0b got sum=%h c/o/z=%b lat=%0d want sum=%h c/o/z=%b lat=%0d",
                         i, ra, rb, rc, rs, sum, {cout, ovf, zero}, lat, es, {eco, eov, ez}, NUM_CHUNKS);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume;
        end
    endtask

`ifdef WIDE_ADD_SUB_EN
    task automatic test_sub;
        logic [WIDTH-1:0] ta [3];
        logic [WIDTH-1:0] tb [3];
        logic [WIDTH-1:0] es [3];
        logic [1:0]       ef [3];   // {cout, ovf}
        int lat;
        ta[0] = 64'd5;                   tb[0] = 64'd7; es[0] = 64'hFFFF_FFFF_FFFF_FFFE; ef[0] = 2'b00;
        ta[1] = 64'd7;                   tb[1] = 64'd5; es[1] = 64'd2;                   ef[1] = 2'b10;
        ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'd1; es[2] = 64'h7FFF_FFFF_FFFF_FFFF; ef[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b0, 1'b1);
            wait_done(lat);
            tests++; if (sum !== es[i] || {cout, ovf} !== ef[i]) begin
                fails++; $display("FAIL sub%0d: sum=%h cout/ovf=%b want %h/%b", i, sum, {cout, ovf}, es[i], ef[i]);
            end
            consume;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        test_random;
`ifdef WIDE_ADD_SUB_EN
        test_sub;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
